apb_multi_master: RTL
=====================

# apb_multi_master

Parametrised APB bridge/master that turns a simple valid/ready request port into APB3 transfers on up to 2**SEL_W slaves. It is the successor to our fixed 8-bit, two-slave (GPIO/UART) master: address and data widths are generic, the slave-select decode is parametrised, and it adds wait-state tracking, PSLVERR reporting, a wait-state timeout and back-to-back transfers. It sits between the test/processor side and the peripheral slaves (GPIO, UART TX/RX, future blocks).

## Interface
- ADDR_W, 8, address width; must be > SEL_W.
- DATA_W, 8, data width.
- SEL_W, 1, slave-select field width; NUM_SLV = 2**SEL_W.
- TIMEOUT, 255, max ACCESS cycles with PREADY low before forced termination; 0 disables timeout.

- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
- rsp_err  out  1  slave error or timeout; valid with rsp_valid.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  NUM_SLV*DATA_W  slave read data, slave k at bits [k*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS.
- Decode: slave index s = req_addr[ADDR_W-1 -: SEL_W], latched at acceptance; every index is mapped.
- IDLE: req_ready=1. On accept, latch addr/write/wdata/s into PADDR/PWRITE/PWDATA/sel register -> SETUP.
- SETUP: PSEL[s]=1, PENABLE=0, req_ready=0 -> ACCESS unconditionally.
- ACCESS: PSEL[s]=1, PENABLE=1. Only PREADY[s], PSLVERR[s], PRDATA slice s are observed; other slaves ignored.
  - done = PREADY[s] | timeout_hit.
  - !done: stay; wait counter increments.
  - done: capture rsp_rdata = PRDATA[s] on read with PREADY[s], else 0; rsp_err = PSLVERR[s] & PREADY[s] | timeout_hit; pulse rsp_valid next cycle.
  - req_ready = done in ACCESS. If req_valid also high: accept, relatch -> SETUP (back-to-back, PSEL may change to another slave). Else -> IDLE with PSEL=0, PENABLE=0.
- Timeout: counter clog2(TIMEOUT+1) bits, cleared on entering ACCESS; timeout_hit = (TIMEOUT!=0) & (count==TIMEOUT) & !PREADY[s]. Counter saturates, never wraps.
- PADDR/PWRITE/PWDATA held stable from SETUP through last ACCESS cycle; retain last value in IDLE.
- rsp_rdata/rsp_err hold last value between pulses.

## Timing
- Reset: state IDLE; req_ready=1 (asserted the cycle after PRESET deasserts, 0 during reset); PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Accept at edge T -> SETUP cycle T+1 -> ACCESS from T+2 -> with zero wait states rsp_valid high cycle T+3.
- Each PREADY-low ACCESS cycle adds one cycle of latency; max ACCESS length TIMEOUT+1 cycles.
- Back-to-back: throughput one transfer per 2 cycles at zero wait states; no IDLE cycle inserted.
- PRESET mid-transfer: abort immediately, PSEL/PENABLE drop next edge, no rsp_valid for the aborted transfer.
- req_valid ignored while req_ready=0; requester must hold fields until accepted.

## Test plan
- Reset: hold PRESET 3 cycles during an ACCESS -> all outputs zero, no rsp_valid, req_ready=1 after release.
- Write addr 0x83 data 0xF9, slave 1 PREADY always high -> PSEL=2'b10 at T+1, PENABLE at T+2, rsp_valid T+3, rsp_err=0, PWDATA=0xF9 stable both phases.
- Read addr 0x02, slave 0 holds PREADY low 4 cycles, PRDATA=0xC5 -> ACCESS lasts 5 cycles, rsp_rdata=0xC5, rsp_err=0; slave 1 PREADY toggling has no effect.
- Back-to-back: write 0x81 then read 0x01 presented continuously -> second SETUP directly follows first ACCESS, PSEL 2'b10 then 2'b01, two rsp_valid pulses 2 cycles apart.
- Error: slave 1 returns PREADY=1, PSLVERR=1 on read -> rsp_err=1, rsp_rdata=0x00.
- Timeout with TIMEOUT=4: slave never ready -> ACCESS exactly 5 cycles, rsp_err=1, rsp_rdata=0, back to IDLE; TIMEOUT=0 build waits indefinitely (checked 1000 cycles).

Source files
------------

// File: rtl/apb_multi_master.sv
// Parametrised APB3 master: accepts valid/ready requests and runs SETUP/ACCESS
// transfers on a decoded slave, with PSLVERR reporting and a wait-state timeout.
module apb_multi_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [(2**SEL_W)-1:0]       PSEL,
    output logic                        PENABLE,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    input  logic [(2**SEL_W)*DATA_W-1:0] PRDATA,
    input  logic [(2**SEL_W)-1:0]       PREADY,
    input  logic [(2**SEL_W)-1:0]       PSLVERR
);
    localparam int NUM_SLV = 2**SEL_W;
    // A zero TIMEOUT still needs a legal one-bit counter; it simply never moves.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t              r_state, w_next;
    logic [SEL_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_pready, w_pslverr, w_timeout_hit, w_done, w_accept;
    logic [DATA_W-1:0]   w_prdata;

    // Only the addressed slave's response lines are ever looked at.
    assign w_pready      = PREADY[r_sel];
    assign w_pslverr     = PSLVERR[r_sel];
    assign w_prdata      = PRDATA[int'(r_sel)*DATA_W +: DATA_W];
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_MAX) && !w_pready;
    assign w_done        = (r_state == S_ACCESS) && (w_pready || w_timeout_hit);
    assign w_accept      = req_valid && req_ready;

    always_ff @(posedge PCLK) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done) w_next = w_accept ? S_SETUP : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (r_state)
            S_IDLE:   req_ready = !PRESET;
            S_SETUP:  PSEL = NUM_SLV'(1) << r_sel;
            S_ACCESS: begin
                PSEL      = NUM_SLV'(1) << r_sel;
                PENABLE   = 1'b1;
                req_ready = !PRESET && w_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_sel       <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel    <= req_addr[ADDR_W-1 -: SEL_W];
                r_paddr  <= req_addr;
                r_pwrite <= req_write;
                r_pwdata <= req_wdata;
            end
            // Saturating wait counter, restarted for every new ACCESS phase.
            if (r_state == S_SETUP)
                r_cnt <= '0;
            else if (r_state == S_ACCESS && !w_done && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_rdata <= (!r_pwrite && w_pready) ? w_prdata : '0;
                r_rsp_err   <= (w_pslverr && w_pready) || w_timeout_hit;
            end
        end
    end

    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
